regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 89 ++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, optional write bypass and a
// per-register busy scoreboard for tracking outstanding producers.
module regfile_sb #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    data_adr,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    a1,
  input  logic [AW-1:0]    a2,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             busy1,
  output logic             busy2,
  output logic             stall
);

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  // In range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DepthW) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [WIDTH-1:0] rf_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             wr_acc, iss_acc;

  assign wr_acc  = we & ~rst & addr_ok(data_adr);
  assign iss_acc = iss_valid & ~rst & addr_ok(iss_rd);

  // Issue is applied after write-back so a same-edge collision leaves the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_acc && (data_adr == AW'(i))) busy_d[i] = 1'b0;
      if (iss_acc && (iss_rd == AW'(i)))  busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_acc && (data_adr == AW'(i))) rf_q[i] <= data_in;
      end
    end
  end

  logic [AW-1:0]    ra [2];
  logic [WIDTH-1:0] rd [2];
  logic             rb [2];

  assign ra[0] = a1;
  assign ra[1] = a2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = '0;
      rb[p] = 1'b0;
      if (addr_ok(ra[p])) begin
        if ((BYPASS != 0) && wr_acc && (data_adr == ra[p])) begin
          rd[p] = data_in;
        end else begin
          rd[p] = rf_q[ra[p]];
          rb[p] = busy_q[ra[p]];
        end
      end
    end
  end

  assign out1  = rd[0];
  assign out2  = rd[1];
  assign busy1 = rb[0];
  assign busy2 = rb[1];
  assign stall = rb[0] | rb[1];

endmodule
